// File: rtl/rom_pkg.sv
// Shared constants for the Koblitz constant table and its reverse-lookup engine.
// Both the forward table and rom_index_search read their contents from here.
package rom_pkg;

    localparam logic [15:0] C0 = 16'd0;
    localparam logic [15:0] C1 = 16'd1;
    localparam logic [15:0] C2 = 16'd32;
    localparam logic [15:0] C3 = 16'd128;
    localparam logic [15:0] C4 = 16'd4096;

    localparam int unsigned DEFAULT_NUM_ENTRIES = 5;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Unpopulated addresses read as zero.
    function automatic logic [15:0] rom_value(input logic [ADDR_W-1:0] addr);
        logic [15:0] val;
        val = 16'd0;
        unique case (addr)
            3'd0: val = C0;
            3'd1: val = C1;
            3'd2: val = C2;
            3'd3: val = C3;
            3'd4: val = C4;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/rom_const_table.sv
// Combinational 8-entry constant table, 3-bit address to 16-bit value.
module rom_const_table
    import rom_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    always_comb begin
        data = rom_value(addr);
    end

endmodule

// File: rtl/rom_index_search.sv
// Reverse lookup of a 16-bit constant into its table index by sequential scan,
// with a start/done handshake and registered results.
module rom_index_search
    import rom_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = DEFAULT_NUM_ENTRIES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       target,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] index
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       tgt_q, tgt_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       rom_data;

    rom_const_table u_table (
        .addr (addr_q),
        .data (rom_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        found_d = found_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tgt_d   = target;
                    addr_d  = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Lowest matching address wins since the scan starts at zero.
                if (rom_data == tgt_q) begin
                    index_d = addr_q;
                    found_d = 1'b1;
                    state_d = StDone;
                end else if (addr_q == LAST_ADDR) begin
                    index_d = '0;
                    found_d = 1'b0;
                    state_d = StDone;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Status flags are registered from the next state so they align with it.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            tgt_q   <= '0;
            found_q <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            found_q <= found_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign index = index_q;

endmodule

// File: tb/tb_rom_index_search.sv
// Scoreboard bench for rom_index_search: expectations are queued at accept and
// compared when done pulses; a second instance covers NUM_ENTRIES=3.
module tb_rom_index_search;

    typedef struct packed {
        logic        found;
        logic [2:0]  idx;
        int unsigned lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] target;
    logic        busy, done, found;
    logic [2:0]  index;

    logic        start3;
    logic [15:0] target3;
    logic        busy3, done3, found3;
    logic [2:0]  index3;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned cyc;
    int unsigned acc;
    int unsigned bcnt;
    logic        prev_found;
    logic [2:0]  prev_index;
    exp_t        exp_q[$];

    rom_index_search #(.NUM_ENTRIES(5)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .index  (index)
    );

    rom_index_search #(.NUM_ENTRIES(3)) u_dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start3),
        .target (target3),
        .busy   (busy3),
        .done   (done3),
        .found  (found3),
        .index  (index3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compares on each done pulse, checks results hold while busy.
    always @(negedge clk) begin
        if (busy) bcnt++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("found", {31'd0, found}, {31'd0, e.found});
                check("index", {29'd0, index}, {29'd0, e.idx});
                check("done_cycle", cyc - acc + 1, e.lat);
                check("busy_cycles", bcnt, e.lat);
                check("busy_in_done", {31'd0, busy}, 32'd1);
                prev_found = e.found;
                prev_index = e.idx;
            end
        end else if (busy) begin
            check("found_hold", {31'd0, found}, {31'd0, prev_found});
            check("index_hold", {29'd0, index}, {29'd0, prev_index});
        end
    end

    // Raise start and wait for the accepting edge (busy rising); may be called in DONE.
    task automatic launch(input logic [15:0] t, input logic ef, input logic [2:0] ei,
                          input int unsigned lat, input bit hold);
        exp_t e;
        bit ok;
        ok = 1'b0;
        start  = 1'b1;
        target = t;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        acc  = cyc;
        bcnt = 0;
        e.found = ef;
        e.idx   = ei;
        e.lat   = lat;
        exp_q.push_back(e);
        if (!hold) start = 1'b0;
    endtask

    // Return at negedge+1 of the cycle in which the pending search completed.
    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("done_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        acc        = 0;
        bcnt       = 0;
        prev_found = 1'b0;
        prev_index = 3'd0;
        rst_n      = 1'b0;
        start      = 1'b0;
        target     = 16'd0;
        start3     = 1'b0;
        target3    = 16'd0;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_index", {29'd0, index}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'd32, 1'b1, 3'd2, 4, 1'b0);
        wait_done();
        launch(16'd0, 1'b1, 3'd0, 2, 1'b0);
        wait_done();
        launch(16'd4096, 1'b1, 3'd4, 6, 1'b0);
        wait_done();
        launch(16'd5, 1'b0, 3'd0, 6, 1'b0);
        wait_done();
        launch(16'd1, 1'b1, 3'd1, 3, 1'b0);
        wait_done();

        // start held high and target changed mid-scan; next start goes right after DONE.
        launch(16'd128, 1'b1, 3'd3, 5, 1'b1);
        @(posedge clk);
        #1;
        target = 16'd1;
        wait_done();
        launch(16'd32, 1'b1, 3'd2, 4, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);

        // Asynchronous reset in cycle 2 of a search aborts it without a done pulse.
        launch(16'd4096, 1'b1, 3'd4, 6, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        prev_found = 1'b0;
        prev_index = 3'd0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_found", {31'd0, found}, 32'd0);
        check("mid_rst_index", {29'd0, index}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        launch(16'd1, 1'b1, 3'd1, 3, 1'b0);
        wait_done();

        // NUM_ENTRIES=3: 128 lives at address 3, so this is a miss.
        begin
            int unsigned acc3;
            bit got;
            got = 1'b0;
            @(negedge clk);
            start3  = 1'b1;
            target3 = 16'd128;
            @(posedge clk);
            #1;
            acc3   = cyc;
            start3 = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done3) begin
                    got = 1'b1;
                    check("n3_done_cycle", cyc - acc3 + 1, 32'd4);
                    check("n3_found", {31'd0, found3}, 32'd0);
                    check("n3_index", {29'd0, index3}, 32'd0);
                    break;
                end
            end
            if (!got) check("n3_done_timeout", 32'd1, 32'd0);
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) check("pending_at_end", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
